// File: rtl/rv32_mem.sv
// RV32 memory-access stage: one outstanding data-bus request, load align/extend,
// store strobes, branch resolution, and registered results toward writeback/fetch.
module rv32_mem (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_en_in,
  input  logic        mem_write_en_in,
  input  logic [1:0]  mem_width_in,
  input  logic        mem_zero_extend_in,
  input  logic [1:0]  branch_op_in,
  input  logic [4:0]  rd_in,
  input  logic        rd_writeback_in,
  input  logic [31:0] result_in,
  input  logic [31:0] rs2_value_in,
  input  logic [31:0] branch_pc_in,
  output logic [31:0] bus_address_out,
  output logic        bus_read_out,
  output logic        bus_write_out,
  output logic        bus_valid_out,
  output logic [3:0]  bus_write_mask_out,
  output logic [31:0] bus_write_value_out,
  input  logic [31:0] bus_read_value_in,
  input  logic        bus_ready_in,
  output logic        stall_out,
  output logic [4:0]  rd_out,
  output logic        rd_writeback_out,
  output logic [31:0] rd_value_out,
  output logic        branch_taken_out,
  output logic [31:0] branch_pc_out,
  output logic        fault_out
);

  // state | meaning
  // IDLE  | nothing outstanding; pass-through, fault, or accept a new access
  // BUSY  | bus request valid, waiting for bus_ready_in
  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, state_nxt;

  logic        mem_op;
  logic        misaligned;
  logic        taken;
  logic [3:0]  mask_nxt;
  logic [31:0] wval_nxt;

  logic [4:0]  rd_q;
  logic        wb_q;
  logic [1:0]  width_q;
  logic        zext_q;
  logic        write_q;
  logic [1:0]  off_q;

  logic [31:0] byte_shift;
  logic [31:0] half_shift;
  logic [31:0] load_data;

  always_comb begin
    mem_op = mem_read_en_in | mem_write_en_in;

    case (mem_width_in)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = result_in[0];
      2'b10:   misaligned = |result_in[1:0];
      default: misaligned = 1'b1;
    endcase

    case (branch_op_in)
      2'b00:   taken = 1'b0;
      2'b01:   taken = (result_in == 32'd0);
      2'b10:   taken = (result_in != 32'd0);
      default: taken = 1'b1;
    endcase

    case (mem_width_in)
      2'b00: begin
        mask_nxt = 4'b0001 << result_in[1:0];
        wval_nxt = {4{rs2_value_in[7:0]}};
      end
      2'b01: begin
        mask_nxt = 4'b0011 << result_in[1:0];
        wval_nxt = {2{rs2_value_in[15:0]}};
      end
      default: begin
        mask_nxt = 4'b1111;
        wval_nxt = rs2_value_in;
      end
    endcase
    // a read-only access carries no strobes
    if (!mem_write_en_in) mask_nxt = 4'b0000;
  end

  always_comb begin
    byte_shift = bus_read_value_in >> {off_q, 3'b000};
    half_shift = bus_read_value_in >> {off_q[1], 4'b0000};
    case (width_q)
      2'b00:   load_data = zext_q ? {24'd0, byte_shift[7:0]}
                                  : {{24{byte_shift[7]}}, byte_shift[7:0]};
      2'b01:   load_data = zext_q ? {16'd0, half_shift[15:0]}
                                  : {{16{half_shift[15]}}, half_shift[15:0]};
      default: load_data = bus_read_value_in;
    endcase
  end

  always_comb begin
    state_nxt = state;
    stall_out = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op && !misaligned) begin
          stall_out = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        stall_out = !bus_ready_in;
        if (bus_ready_in) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_address_out     <= '0;
      bus_read_out        <= 1'b0;
      bus_write_out       <= 1'b0;
      bus_valid_out       <= 1'b0;
      bus_write_mask_out  <= '0;
      bus_write_value_out <= '0;
      rd_out              <= '0;
      rd_writeback_out    <= 1'b0;
      rd_value_out        <= '0;
      branch_taken_out    <= 1'b0;
      branch_pc_out       <= '0;
      fault_out           <= 1'b0;
      rd_q                <= '0;
      wb_q                <= 1'b0;
      width_q             <= '0;
      zext_q              <= 1'b0;
      write_q             <= 1'b0;
      off_q               <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!mem_op) begin
            rd_out           <= rd_in;
            rd_writeback_out <= rd_writeback_in;
            rd_value_out     <= result_in;
            branch_taken_out <= taken;
            branch_pc_out    <= branch_pc_in;
            fault_out        <= 1'b0;
          end else if (misaligned) begin
            fault_out        <= 1'b1;
            rd_writeback_out <= 1'b0;
            branch_taken_out <= 1'b0;
          end else begin
            rd_q                <= rd_in;
            wb_q                <= rd_writeback_in;
            width_q             <= mem_width_in;
            zext_q              <= mem_zero_extend_in;
            write_q             <= mem_write_en_in;
            off_q               <= result_in[1:0];
            bus_address_out     <= {result_in[31:2], 2'b00};
            bus_read_out        <= !mem_write_en_in;
            bus_write_out       <= mem_write_en_in;
            bus_write_mask_out  <= mask_nxt;
            bus_write_value_out <= wval_nxt;
            bus_valid_out       <= 1'b1;
            rd_writeback_out    <= 1'b0;
            branch_taken_out    <= 1'b0;
            fault_out           <= 1'b0;
          end
        end
        BUSY: begin
          branch_taken_out <= 1'b0;
          fault_out        <= 1'b0;
          if (bus_ready_in) begin
            bus_valid_out    <= 1'b0;
            rd_out           <= rd_q;
            rd_writeback_out <= wb_q & !write_q;
            if (!write_q) rd_value_out <= load_data;
          end else begin
            rd_writeback_out <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_mem.sv
// Bench for rv32_mem: directed scenarios with literal expectations, then random
// instruction/bus traffic checked every cycle against a behavioural model.
module tb_rv32_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_en_in, mem_write_en_in;
  logic [1:0]  mem_width_in;
  logic        mem_zero_extend_in;
  logic [1:0]  branch_op_in;
  logic [4:0]  rd_in;
  logic        rd_writeback_in;
  logic [31:0] result_in, rs2_value_in, branch_pc_in;
  logic [31:0] bus_address_out;
  logic        bus_read_out, bus_write_out, bus_valid_out;
  logic [3:0]  bus_write_mask_out;
  logic [31:0] bus_write_value_out;
  logic [31:0] bus_read_value_in;
  logic        bus_ready_in;
  logic        stall_out;
  logic [4:0]  rd_out;
  logic        rd_writeback_out;
  logic [31:0] rd_value_out;
  logic        branch_taken_out;
  logic [31:0] branch_pc_out;
  logic        fault_out;

  int errors = 0;
  int checks = 0;

  rv32_mem dut (
    .clk(clk), .reset(reset),
    .mem_read_en_in(mem_read_en_in), .mem_write_en_in(mem_write_en_in),
    .mem_width_in(mem_width_in), .mem_zero_extend_in(mem_zero_extend_in),
    .branch_op_in(branch_op_in), .rd_in(rd_in), .rd_writeback_in(rd_writeback_in),
    .result_in(result_in), .rs2_value_in(rs2_value_in), .branch_pc_in(branch_pc_in),
    .bus_address_out(bus_address_out), .bus_read_out(bus_read_out),
    .bus_write_out(bus_write_out), .bus_valid_out(bus_valid_out),
    .bus_write_mask_out(bus_write_mask_out), .bus_write_value_out(bus_write_value_out),
    .bus_read_value_in(bus_read_value_in), .bus_ready_in(bus_ready_in),
    .stall_out(stall_out), .rd_out(rd_out), .rd_writeback_out(rd_writeback_out),
    .rd_value_out(rd_value_out), .branch_taken_out(branch_taken_out),
    .branch_pc_out(branch_pc_out), .fault_out(fault_out)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit misal(input logic [1:0] w, input logic [31:0] a);
    if (w == 2'd3) return 1'b1;
    if (w == 2'd2) return a[1:0] != 2'd0;
    if (w == 2'd1) return a[0];
    return 1'b0;
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] rv, input logic [1:0] w,
                                           input logic [1:0] off, input bit zx);
    int nbytes;
    logic [63:0] fmask, field;
    nbytes = 1 << w;
    fmask  = (64'd1 << (8 * nbytes)) - 64'd1;
    field  = (64'(rv) >> (8 * int'(off))) & fmask;
    if (!zx && field[8 * nbytes - 1]) field = field | ~fmask;
    return field[31:0];
  endfunction

  function automatic logic [3:0] st_mask(input logic [1:0] w, input logic [1:0] off);
    int nbytes;
    nbytes = 1 << w;
    return 4'(((1 << nbytes) - 1) << int'(off));
  endfunction

  function automatic logic [31:0] st_val(input logic [31:0] d, input logic [1:0] w);
    int nbytes;
    logic [63:0] f, r;
    nbytes = 1 << w;
    f = 64'(d) & ((64'd1 << (8 * nbytes)) - 64'd1);
    r = 64'd0;
    for (int k = 0; k < 4 / nbytes; k++) r = r | (f << (8 * nbytes * k));
    return r[31:0];
  endfunction

  // model: pending access plus the expected registered outputs;
  // k_* say whether a field's value is defined this cycle
  bit        chk_en = 1'b0;
  bit        m_busy, m_wb, m_zext, m_write;
  bit [4:0]  m_rd;
  bit [1:0]  m_width, m_off;
  bit [31:0] e_addr, e_wval, e_rdval, e_bpc;
  bit        e_read, e_write, e_valid, e_wb, e_br, e_fault;
  bit [3:0]  e_mask;
  bit [4:0]  e_rd;
  bit        k_bus, k_rd, k_bpc;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0;
      e_addr = '0; e_wval = '0; e_rdval = '0; e_bpc = '0; e_mask = '0; e_rd = '0;
      e_read = 1'b0; e_write = 1'b0; e_valid = 1'b0; e_wb = 1'b0; e_br = 1'b0; e_fault = 1'b0;
      k_bus = 1'b1; k_rd = 1'b1; k_bpc = 1'b1;
    end else if (!m_busy) begin
      k_bus = 1'b0;
      e_valid = 1'b0;
      if (!(mem_read_en_in || mem_write_en_in)) begin
        e_rd = rd_in; e_wb = rd_writeback_in; e_rdval = result_in;
        e_fault = 1'b0; e_bpc = branch_pc_in;
        case (branch_op_in)
          2'd0:    e_br = 1'b0;
          2'd1:    e_br = (result_in == 32'd0);
          2'd2:    e_br = (result_in != 32'd0);
          default: e_br = 1'b1;
        endcase
        k_rd = 1'b1; k_bpc = 1'b1;
      end else if (misal(mem_width_in, result_in)) begin
        e_fault = 1'b1; e_wb = 1'b0; e_br = 1'b0; k_rd = 1'b0; k_bpc = 1'b0;
      end else begin
        m_busy = 1'b1;
        m_rd = rd_in; m_wb = rd_writeback_in; m_width = mem_width_in;
        m_zext = mem_zero_extend_in; m_write = mem_write_en_in; m_off = result_in[1:0];
        e_addr  = result_in & 32'hFFFF_FFFC;
        e_write = m_write; e_read = !m_write; e_valid = 1'b1;
        e_mask  = m_write ? st_mask(m_width, m_off) : 4'd0;
        e_wval  = st_val(rs2_value_in, m_width);
        e_wb = 1'b0; e_br = 1'b0; e_fault = 1'b0;
        k_bus = 1'b1; k_rd = 1'b0; k_bpc = 1'b0;
      end
    end else begin
      e_br = 1'b0; e_fault = 1'b0; k_bpc = 1'b0;
      if (!bus_ready_in) begin
        e_wb = 1'b0; k_rd = 1'b0;
      end else begin
        m_busy = 1'b0; e_valid = 1'b0; k_bus = 1'b0;
        if (m_write) begin
          e_wb = 1'b0; k_rd = 1'b0;
        end else begin
          e_wb = m_wb; e_rd = m_rd;
          e_rdval = load_val(bus_read_value_in, m_width, m_off, m_zext);
          k_rd = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic e_stall;
    if (chk_en) begin
      e_stall = m_busy ? !bus_ready_in
                       : ((mem_read_en_in || mem_write_en_in) && !misal(mem_width_in, result_in));
      check1("stall", stall_out, e_stall);
      check1("bus_valid", bus_valid_out, e_valid);
      check1("rd_writeback", rd_writeback_out, e_wb);
      check1("branch_taken", branch_taken_out, e_br);
      check1("fault", fault_out, e_fault);
      if (k_bus) begin
        check32("bus_address", bus_address_out, e_addr);
        check1("bus_read", bus_read_out, e_read);
        check1("bus_write", bus_write_out, e_write);
        check32("bus_mask", 32'(bus_write_mask_out), 32'(e_mask));
        if (e_write || !e_valid) check32("bus_wvalue", bus_write_value_out, e_wval);
      end
      if (k_rd) begin
        check32("rd", 32'(rd_out), 32'(e_rd));
        check32("rd_value", rd_value_out, e_rdval);
      end
      if (k_bpc) check32("branch_pc", branch_pc_out, e_bpc);
    end
  end

  task automatic set_instr(input logic re, input logic we, input logic [1:0] w, input logic zx,
                           input logic [1:0] bop, input logic [4:0] rd, input logic wb,
                           input logic [31:0] res, input logic [31:0] rs2, input logic [31:0] bpc);
    mem_read_en_in = re; mem_write_en_in = we; mem_width_in = w; mem_zero_extend_in = zx;
    branch_op_in = bop; rd_in = rd; rd_writeback_in = wb;
    result_in = res; rs2_value_in = rs2; branch_pc_in = bpc;
  endtask

  task automatic idle_instr();
    set_instr(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0);
  endtask

  // issue one aligned access, hold it through BUSY, ready after 'waits' low cycles
  task automatic do_mem(input logic re, input logic we, input logic [1:0] w, input logic zx,
                        input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] rs2,
                        input int waits, input logic [31:0] rv, output int stalls,
                        output logic [31:0] c_addr, output logic [3:0] c_mask,
                        output logic [31:0] c_wval, output logic c_write);
    @(posedge clk); #2;
    set_instr(re, we, w, zx, 2'd0, rd, 1'b1, addr, rs2, 32'd0);
    bus_ready_in = 1'b0;
    @(negedge clk);
    stalls = int'(stall_out);
    c_addr = '0; c_mask = '0; c_wval = '0; c_write = 1'b0;
    for (int i = 0; i <= waits; i++) begin
      @(posedge clk); #2;
      bus_ready_in = (i == waits);
      bus_read_value_in = rv;
      @(negedge clk);
      stalls += int'(stall_out);
      if (i == 0) begin
        c_addr = bus_address_out; c_mask = bus_write_mask_out;
        c_wval = bus_write_value_out; c_write = bus_write_out;
      end
    end
    @(posedge clk); #2;
    idle_instr();
    bus_ready_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic rand_instr();
    int kind;
    kind = $urandom_range(0, 3);
    mem_read_en_in  = (kind == 1) || (kind == 3 && $urandom_range(0, 1) == 1);
    mem_write_en_in = (kind == 2) || (kind == 3 && !mem_read_en_in) || (kind == 3 && $urandom_range(0, 1) == 1);
    mem_width_in       = 2'($urandom_range(0, 3));
    mem_zero_extend_in = 1'($urandom);
    branch_op_in       = 2'($urandom_range(0, 3));
    rd_in              = 5'($urandom);
    rd_writeback_in    = 1'($urandom);
    result_in          = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
    if ((mem_read_en_in || mem_write_en_in) && $urandom_range(0, 2) != 0) begin
      if (mem_width_in == 2'd1) result_in[0] = 1'b0;
      if (mem_width_in == 2'd2) result_in[1:0] = 2'd0;
    end
    rs2_value_in = 32'($urandom);
    branch_pc_in = 32'($urandom);
  endtask

  int          stalls;
  logic [31:0] c_addr, c_wval;
  logic [3:0]  c_mask;
  logic        c_write;
  logic        last_stall;

  initial begin
    reset = 1'b1;
    idle_instr();
    bus_ready_in = 1'b0;
    bus_read_value_in = 32'd0;
    @(posedge clk); #2;
    chk_en = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;

    // pass-through
    @(posedge clk); #2;
    set_instr(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 5'd5, 1'b1, 32'h0000_1234, 32'd0, 32'd0);
    @(negedge clk);
    check1("pt_stall", stall_out, 1'b0);
    @(posedge clk); #2;
    idle_instr();
    @(negedge clk);
    check32("pt_rd", 32'(rd_out), 32'd5);
    check1("pt_wb", rd_writeback_out, 1'b1);
    check32("pt_value", rd_value_out, 32'h0000_1234);

    // signed byte load, two not-ready cycles
    do_mem(1'b1, 1'b0, 2'd0, 1'b0, 5'd7, 32'h0000_0103, 32'd0, 2, 32'h80AA_BBCC,
           stalls, c_addr, c_mask, c_wval, c_write);
    check32("lb_addr", c_addr, 32'h0000_0100);
    check32("lb_mask", 32'(c_mask), 32'd0);
    check32("lb_stall_cycles", 32'(stalls), 32'd3);
    check32("lb_value", rd_value_out, 32'hFFFF_FF80);
    check32("lb_rd", 32'(rd_out), 32'd7);
    check1("lb_wb", rd_writeback_out, 1'b1);

    do_mem(1'b1, 1'b0, 2'd0, 1'b1, 5'd7, 32'h0000_0103, 32'd0, 0, 32'h80AA_BBCC,
           stalls, c_addr, c_mask, c_wval, c_write);
    check32("lbu_value", rd_value_out, 32'h0000_0080);
    check32("lbu_stall_cycles", 32'(stalls), 32'd1);

    // halfword store, ready immediately
    do_mem(1'b0, 1'b1, 2'd1, 1'b0, 5'd9, 32'h0000_0202, 32'hABCD_1234, 0, 32'd0,
           stalls, c_addr, c_mask, c_wval, c_write);
    check32("sh_mask", 32'(c_mask), 32'h0000_000C);
    check32("sh_wvalue", c_wval, 32'h1234_1234);
    check1("sh_write", c_write, 1'b1);
    check1("sh_wb", rd_writeback_out, 1'b0);

    // misaligned word load
    @(posedge clk); #2;
    set_instr(1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 5'd4, 1'b1, 32'h0000_0101, 32'd0, 32'd0);
    @(negedge clk);
    check1("mis_stall", stall_out, 1'b0);
    @(posedge clk); #2;
    idle_instr();
    @(negedge clk);
    check1("mis_fault", fault_out, 1'b1);
    check1("mis_wb", rd_writeback_out, 1'b0);
    check1("mis_valid", bus_valid_out, 1'b0);
    @(posedge clk); #2;
    @(negedge clk);
    check1("mis_fault_pulse", fault_out, 1'b0);

    // branch taken when result==0, then not taken when result==1
    @(posedge clk); #2;
    set_instr(1'b0, 1'b0, 2'd0, 1'b0, 2'd1, 5'd0, 1'b0, 32'd0, 32'd0, 32'h0000_0400);
    @(posedge clk); #2;
    idle_instr();
    @(negedge clk);
    check1("br_taken", branch_taken_out, 1'b1);
    check32("br_pc", branch_pc_out, 32'h0000_0400);
    @(posedge clk); #2;
    set_instr(1'b0, 1'b0, 2'd0, 1'b0, 2'd1, 5'd0, 1'b0, 32'd1, 32'd0, 32'h0000_0400);
    @(negedge clk);
    check1("br_pulse", branch_taken_out, 1'b0);
    @(posedge clk); #2;
    idle_instr();
    @(negedge clk);
    check1("br_not_taken", branch_taken_out, 1'b0);

    // reset while BUSY abandons the request
    @(posedge clk); #2;
    set_instr(1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 5'd6, 1'b1, 32'h0000_0300, 32'd0, 32'd0);
    bus_ready_in = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    @(negedge clk);
    check1("rst_busy_valid", bus_valid_out, 1'b1);
    @(posedge clk); #2;
    reset = 1'b0;
    idle_instr();
    @(negedge clk);
    check1("rst_valid", bus_valid_out, 1'b0);
    check1("rst_stall", stall_out, 1'b0);
    check32("rst_addr", bus_address_out, 32'd0);
    check32("rst_rd", 32'(rd_out), 32'd0);
    check32("rst_value", rd_value_out, 32'd0);
    check1("rst_wb", rd_writeback_out, 1'b0);
    check32("rst_bpc", branch_pc_out, 32'd0);
    @(posedge clk); #2;
    set_instr(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 5'd3, 1'b1, 32'h0000_CAFE, 32'd0, 32'd0);
    @(posedge clk); #2;
    idle_instr();
    @(negedge clk);
    check32("post_rst_rd", 32'(rd_out), 32'd3);
    check1("post_rst_wb", rd_writeback_out, 1'b1);
    check32("post_rst_value", rd_value_out, 32'h0000_CAFE);

    // random traffic; a new instruction is presented only after a non-stalled cycle
    last_stall = 1'b0;
    repeat (3000) begin
      @(posedge clk); #2;
      reset = ($urandom_range(0, 249) == 0);
      if (!last_stall) rand_instr();
      bus_ready_in = ($urandom_range(0, 2) != 0);
      bus_read_value_in = 32'($urandom);
      @(negedge clk);
      last_stall = stall_out;
    end

    @(posedge clk); #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32_mem.md
Name: rv32_mem

Overview:
Memory-access pipeline stage. It sits directly downstream of the execute stage and consumes that stage's registered control and data outputs: memory enables, width, zero-extend, branch op, rd, result, rs2 value and branch PC. It drives a single-outstanding data-bus request, aligns and extends load data, and generates store byte strobes. It resolves branches, then registers the results toward writeback and fetch, stalling upstream while a bus access is pending.

Parameters:
none (RV32 fixed: 32-bit data/address, 5-bit register index)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high
mem_read_en_in  input  1  load request
mem_write_en_in  input  1  store request
mem_width_in  input  2  00 byte, 01 half, 10 word, 11 reserved
mem_zero_extend_in  input  1  loads: 1 zero-extend, 0 sign-extend
branch_op_in  input  2  00 never, 01 taken if result==0, 10 taken if result!=0, 11 always
rd_in  input  5  destination register
rd_writeback_in  input  1  destination write enable
result_in  input  32  ALU result; also the memory byte address
rs2_value_in  input  32  store data
branch_pc_in  input  32  branch target
bus_address_out  output  32  word-aligned address ({result[31:2],2'b00})
bus_read_out  output  1  read request qualifier
bus_write_out  output  1  write request qualifier
bus_valid_out  output  1  request valid
bus_write_mask_out  output  4  byte strobes, bit n = byte lane n
bus_write_value_out  output  32  lane-replicated store data
bus_read_value_in  input  32  read data, valid with bus_ready_in
bus_ready_in  input  1  request completes this cycle
stall_out  output  1  upstream must hold its inputs stable
rd_out  output  5  to writeback
rd_writeback_out  output  1  to writeback
rd_value_out  output  32  to writeback and forwarding
branch_taken_out  output  1  one-cycle redirect pulse
branch_pc_out  output  32  redirect target
fault_out  output  1  one-cycle misaligned or reserved-width pulse

Behaviour:
- Reset: state IDLE; every output register and bus output is 0.
- Mem op = read_en|write_en. Misaligned: half with result[0]=1, word with result[1:0]!=0, or width 11. A misaligned access makes no bus request.
- FSM IDLE/BUSY.
- IDLE, no mem op: one-cycle pass-through.
  - rd_out <= rd_in; rd_writeback_out <= rd_writeback_in; rd_value_out <= result_in.
  - branch_taken_out per branch_op_in on result_in; branch_pc_out <= branch_pc_in. stall_out=0.
- IDLE, misaligned mem op: fault_out <= 1, rd_writeback_out <= 0, branch_taken_out <= 0. No stall, stays IDLE.
- IDLE, aligned mem op (accept cycle):
  - stall_out=1 combinationally.
  - Latch rd, rd_writeback, width, zero_extend, read/write and byte offset; register bus outputs; next state BUSY.
  - Pipeline outputs take a bubble: rd_writeback_out, branch_taken_out and fault_out <= 0.
- BUSY:
  - bus_valid_out=1; all bus outputs held stable.
  - stall_out = !bus_ready_in.
  - If !ready: bubble on pipeline outputs.
  - If ready: bus_valid_out <= 0; IDLE next.
    - Load: rd_value_out <= extended data. Store: rd_writeback_out <= 0.
    - branch_taken_out <= 0.
- Load extract:
  - byte = read_value >> (8*offset)[7:0]; half = read_value >> (16*offset[1])[15:0]; word as-is.
  - Extend to 32 bits per zero_extend.
- Store:
  - byte: mask 0001<<offset, value {4{rs2[7:0]}}.
  - half: mask 0011<<offset, value {2{rs2[15:0]}}.
  - word: mask 1111, value rs2.
  - Reads drive mask 0000.
- Read and write both asserted: treated as write.
- Loads with rd=0 still complete the bus access; rd_writeback_out follows the latched enable; writeback ignores x0.
- Total memory-op latency is 2 cycles minimum: accept, then BUSY with ready. Each cycle bus_ready_in is low adds one.
- bus_ready_in is ignored in IDLE.
- Reset in BUSY abandons the request: next cycle IDLE, bus_valid_out=0, all outputs 0.
- Upstream contract: inputs are held constant while stall_out=1. The block uses latched copies in BUSY.

Test Plan:
- No mem op: rd_in=5, rd_writeback_in=1, result_in=0x00001234 -> next cycle rd_out=5, rd_writeback_out=1, rd_value_out=0x00001234, stall_out never high.
- Signed byte load:
  - Stimulus: addr 0x00000103, ready low 2 BUSY cycles then high, read_value 0x80AABBCC.
  - Bus: bus_address_out=0x00000100; stall_out high 3 cycles.
  - Result: rd_value_out=0xFFFFFF80. The zero-extend variant gives 0x00000080.
- Halfword store: addr 0x00000202, rs2=0xABCD1234, ready immediately in BUSY -> bus_write_mask_out=1100, bus_write_value_out=0x12341234, bus_write_out=1, rd_writeback_out=0.
- Misaligned word load at 0x00000101 -> bus_valid_out stays 0, fault_out=1 for exactly one cycle, rd_writeback_out=0, stall_out=0.
- Branch: branch_op=01, result=0, branch_pc=0x00000400 -> branch_taken_out=1 one cycle, branch_pc_out=0x00000400. Same stimulus with result=1 -> branch_taken_out=0.
- Reset asserted during BUSY with bus_ready_in=0 -> next cycle bus_valid_out=0, stall_out=0, all outputs 0. A following pass-through instruction completes normally.
